// File: rtl/error_inj_multi.sv
// Multi-lane BER error injector: decade-rate or push-button triggers, bursts of
// programmable length on all masked lanes or one masked lane per burst.
module error_inj_multi #(
    parameter int LANES   = 4,
    parameter int DIGITS  = 6,
    parameter int BURST_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [3:0]         RATE_SEL,
    input  logic [LANES-1:0]   LANE_MASK,
    input  logic               LANE_MODE,
    input  logic [BURST_W-1:0] BURST_LEN,
    input  logic               INJECT_BTN,
    output logic [LANES-1:0]   ERROR,
    output logic               BUSY,
    output logic [CNT_W-1:0]   ERR_COUNT,
    output logic               OVERRUN
);

    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    logic [DIGITS-1:0][3:0] digit_q, digit_d;
    logic [DIGITS:0]        all9_s;
    int                     rate_eff_s;
    logic                   tick_sel_s;
    logic                   btn_s1_q, btn_s2_q, btn_s3_q;
    logic                   btn_edge_s;
    logic                   trig_s;
    logic [PTR_W-1:0]       ptr_q, sel_hi_s, sel_lo_s, sel_idx_s, ptr_next_s;
    logic                   found_hi_s;
    logic [LANES-1:0]       target_s;
    logic [BURST_W-1:0]     remaining_q, remaining_init_s;
    state_t                 state_q;
    logic [LANES-1:0]       error_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overrun_q;

    // Decade chain next state and the "digits 0..k-1 all nine" prefix terms
    always_comb begin
        all9_s[0] = 1'b1;
        digit_d   = digit_q;
        for (int i = 0; i < DIGITS; i++) begin
            all9_s[i+1] = all9_s[i] & (digit_q[i] == 4'd9);
            if (EN && all9_s[i]) begin
                digit_d[i] = (digit_q[i] == 4'd9) ? 4'd0 : digit_q[i] + 4'd1;
            end else begin
                digit_d[i] = digit_q[i];
            end
        end
    end

    // Rate selection (out-of-range codes clamp to the longest period) and trigger merge
    always_comb begin
        rate_eff_s = (int'(RATE_SEL) > DIGITS) ? DIGITS : int'(RATE_SEL);
        tick_sel_s = 1'b0;
        for (int k = 1; k <= DIGITS; k++) begin
            tick_sel_s = tick_sel_s | (EN & all9_s[k] & (rate_eff_s == k));
        end
        btn_edge_s = btn_s2_q & ~btn_s3_q;
        trig_s     = (tick_sel_s | btn_edge_s) & (|LANE_MASK);
    end

    // Round-robin lane pick: lowest set mask bit at or above ptr, else lowest overall
    always_comb begin
        sel_hi_s   = '0;
        sel_lo_s   = '0;
        found_hi_s = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (LANE_MASK[i] && (i >= int'(ptr_q))) begin
                sel_hi_s   = PTR_W'(i);
                found_hi_s = 1'b1;
            end else begin
                sel_hi_s   = sel_hi_s;
                found_hi_s = found_hi_s;
            end
            if (LANE_MASK[i]) begin
                sel_lo_s = PTR_W'(i);
            end else begin
                sel_lo_s = sel_lo_s;
            end
        end
        sel_idx_s  = found_hi_s ? sel_hi_s : sel_lo_s;
        ptr_next_s = (int'(sel_idx_s) == LANES - 1) ? '0 : sel_idx_s + PTR_W'(1);
        target_s   = LANE_MODE ? (LANES'(1'b1) << sel_idx_s) : LANE_MASK;
        remaining_init_s = (BURST_LEN == '0) ? '0 : BURST_LEN - BURST_W'(1);
    end

    // Decade counter chain and button synchroniser / edge flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            digit_q  <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            btn_s1_q <= INJECT_BTN;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
        end
    end

    // Burst FSM with registered lane strobes, counter and sticky overrun
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            error_q     <= '0;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_s) begin
                        state_q     <= ST_BURST;
                        error_q     <= target_s;
                        busy_q      <= 1'b1;
                        remaining_q <= remaining_init_s;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (LANE_MODE) begin
                            ptr_q <= ptr_next_s;
                        end
                    end
                end
                ST_BURST: begin
                    // Triggers are never queued; the last burst cycle also drops them
                    if (trig_s) begin
                        overrun_q <= 1'b1;
                    end
                    if (remaining_q == '0) begin
                        state_q <= ST_IDLE;
                        error_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        remaining_q <= remaining_q - BURST_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    error_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ERROR     = error_q;
    assign BUSY      = busy_q;
    assign ERR_COUNT = count_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_error_inj_multi.sv
// Bench for error_inj_multi: a wide (DIGITS=6, CNT_W=16) and a small (DIGITS=2, CNT_W=4)
// instance share stimulus; a behavioural model is checked every cycle, plus literal pins.
module tb_error_inj_multi;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic [3:0]  RATE_SEL = 4'd0;
    logic [3:0]  LANE_MASK = 4'd0;
    logic        LANE_MODE = 1'b0;
    logic [3:0]  BURST_LEN = 4'd0;
    logic        INJECT_BTN = 1'b0;

    logic [3:0]  err_a, err_b;
    logic        busy_a, busy_b, ovr_a, ovr_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int total = 0;
    int fails = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    error_inj_multi #(.LANES(4), .DIGITS(6), .BURST_W(4), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .RATE_SEL(RATE_SEL), .LANE_MASK(LANE_MASK),
        .LANE_MODE(LANE_MODE), .BURST_LEN(BURST_LEN), .INJECT_BTN(INJECT_BTN),
        .ERROR(err_a), .BUSY(busy_a), .ERR_COUNT(cnt_a), .OVERRUN(ovr_a));

    error_inj_multi #(.LANES(4), .DIGITS(2), .BURST_W(4), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .RATE_SEL(RATE_SEL), .LANE_MASK(LANE_MASK),
        .LANE_MODE(LANE_MODE), .BURST_LEN(BURST_LEN), .INJECT_BTN(INJECT_BTN),
        .ERROR(err_b), .BUSY(busy_b), .ERR_COUNT(cnt_b), .OVERRUN(ovr_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic longint p10(input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    // Model: enabled-cycle count, remaining strobe cycles, and sample history of the button
    int      dig [2] = '{6, 2};
    int      cw  [2] = '{16, 4};
    longint  en_cnt [2] = '{0, 0};
    int      left [2] = '{0, 0};
    logic [3:0] tgt [2] = '{4'd0, 4'd0};
    int      ptr [2] = '{0, 0};
    longint  mcnt [2] = '{0, 0};
    logic    movr [2] = '{1'b0, 1'b0};
    logic [2:0] bh = 3'b000;

    always @(posedge CLK or negedge RST) begin : model
        int k;
        logic be, tk, trig, found;
        int idx;
        if (!RST) begin
            for (int m = 0; m < 2; m++) begin
                en_cnt[m] = 0; left[m] = 0; tgt[m] = 4'd0; ptr[m] = 0;
                mcnt[m] = 0; movr[m] = 1'b0;
            end
            bh = 3'b000;
        end else begin
            be = bh[1] & ~bh[2];
            for (int m = 0; m < 2; m++) begin
                k = (int'(RATE_SEL) > dig[m]) ? dig[m] : int'(RATE_SEL);
                tk = (k != 0) && EN && ((en_cnt[m] % p10(k)) == p10(k) - 1);
                trig = (tk || be) && (LANE_MASK != 4'd0);
                if (left[m] == 0) begin
                    if (trig) begin
                        left[m] = (BURST_LEN == 4'd0) ? 1 : int'(BURST_LEN);
                        if (!LANE_MODE) begin
                            tgt[m] = LANE_MASK;
                        end else begin
                            found = 1'b0;
                            for (int off = 0; off < 4; off++) begin
                                idx = (ptr[m] + off) % 4;
                                if (!found && LANE_MASK[idx]) begin
                                    found = 1'b1;
                                    tgt[m] = 4'b0001 << idx;
                                    ptr[m] = (idx + 1) % 4;
                                end
                            end
                        end
                        if (mcnt[m] < (longint'(1) << cw[m]) - 1) mcnt[m] = mcnt[m] + 1;
                    end
                end else begin
                    if (trig) movr[m] = 1'b1;
                    left[m] = left[m] - 1;
                end
                if (EN) en_cnt[m] = (en_cnt[m] + 1) % p10(dig[m]);
            end
            bh = {bh[1:0], INJECT_BTN};
        end
    end

    // Compare process: every cycle outside reset, both instances against the model
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            chk("err_a",  {28'd0, err_a},  {28'd0, (left[0] > 0) ? tgt[0] : 4'd0});
            chk("busy_a", {31'd0, busy_a}, {31'd0, left[0] > 0});
            chk("cnt_a",  {16'd0, cnt_a},  32'(mcnt[0]));
            chk("ovr_a",  {31'd0, ovr_a},  {31'd0, movr[0]});
            chk("err_b",  {28'd0, err_b},  {28'd0, (left[1] > 0) ? tgt[1] : 4'd0});
            chk("busy_b", {31'd0, busy_b}, {31'd0, left[1] > 0});
            chk("cnt_b",  {28'd0, cnt_b},  32'(mcnt[1]));
            chk("ovr_b",  {31'd0, ovr_b},  {31'd0, movr[1]});
        end
    end

    task automatic do_reset(input logic [3:0] rs, input logic en, input logic [3:0] mask,
                            input logic mode, input logic [3:0] len);
        @(posedge CLK); #2;
        RST = 1'b0; EN = 1'b0; INJECT_BTN = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RATE_SEL = rs; EN = en; LANE_MASK = mask; LANE_MODE = mode; BURST_LEN = len;
        RST = 1'b1;
        @(negedge CLK);
        cyc = 0;
    endtask

    task automatic wait_neg(input int c);
        repeat (c - cyc) @(negedge CLK);
        cyc = c;
    endtask

    task automatic start_of(input int c);
        wait_neg(c - 1);
        @(posedge CLK); #2;
    endtask

    initial begin
        logic [3:0] e;
        // Reset values, idle for 50 cycles
        do_reset(4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        wait_neg(50);
        chk("rst_err", {28'd0, err_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_a}, 32'd0);

        // Periodic 1-in-10, all masked lanes, single-cycle strobes
        do_reset(4'd1, 1'b1, 4'b0101, 1'b0, 4'd1);
        for (int c = 0; c <= 54; c++) begin
            wait_neg(c);
            e = (c > 0 && c % 10 == 0) ? 4'b0101 : 4'b0000;
            chk("periodic_err", {28'd0, err_a}, {28'd0, e});
        end
        chk("periodic_cnt", {16'd0, cnt_a}, 32'd5);

        // Round-robin over mask 1011, bursts of 2
        do_reset(4'd1, 1'b1, 4'b1011, 1'b1, 4'd2);
        for (int c = 0; c <= 45; c++) begin
            wait_neg(c);
            e = (c == 10 || c == 11) ? 4'b0001 : (c == 20 || c == 21) ? 4'b0010 :
                (c == 30 || c == 31) ? 4'b1000 : (c == 40 || c == 41) ? 4'b0001 : 4'b0000;
            chk("rr_err", {28'd0, err_a}, {28'd0, e});
        end

        // Overrun: 12-cycle bursts, tick at 19 dropped
        do_reset(4'd1, 1'b1, 4'b0101, 1'b0, 4'd12);
        for (int c = 0; c <= 35; c++) begin
            wait_neg(c);
            e = ((c >= 10 && c <= 21) || c >= 30) ? 4'b0101 : 4'b0000;
            chk("ovr_err", {28'd0, err_a}, {28'd0, e});
            chk("ovr_flag", {31'd0, ovr_a}, {31'd0, c >= 20});
        end
        chk("ovr_cnt", {16'd0, cnt_a}, 32'd2);

        // Button with EN=0: held 20 cycles, one strobe three edges later
        do_reset(4'd0, 1'b0, 4'b0101, 1'b0, 4'd1);
        start_of(5);
        INJECT_BTN = 1'b1;
        for (int c = 5; c <= 24; c++) begin
            wait_neg(c);
            e = (c == 8) ? 4'b0101 : 4'b0000;
            chk("btn_err", {28'd0, err_a}, {28'd0, e});
        end
        start_of(25);
        INJECT_BTN = 1'b0;
        wait_neg(30);
        chk("btn_cnt", {16'd0, cnt_a}, 32'd1);

        // Button edge coinciding with the cycle-9 tick counts once
        do_reset(4'd1, 1'b1, 4'b0101, 1'b0, 4'd1);
        start_of(7);
        INJECT_BTN = 1'b1;
        wait_neg(10);
        chk("both_err", {28'd0, err_a}, 32'h5);
        wait_neg(15);
        chk("both_cnt", {16'd0, cnt_a}, 32'd1);
        start_of(16);
        INJECT_BTN = 1'b0;

        // Code 9 clamps to DIGITS: period 100 on the small instance, nothing on the wide one
        do_reset(4'd9, 1'b1, 4'b0101, 1'b0, 4'd1);
        wait_neg(99);
        chk("clamp_b_pre", {28'd0, err_b}, 32'd0);
        wait_neg(100);
        chk("clamp_b", {28'd0, err_b}, 32'h5);
        chk("clamp_a", {28'd0, err_a}, 32'd0);

        // 1-in-1000
        do_reset(4'd3, 1'b1, 4'b0101, 1'b0, 4'd1);
        for (int c = 0; c <= 2005; c++) begin
            wait_neg(c);
            if (c == 999 || c == 1000 || c == 1001 || c == 1999 || c == 2000) begin
                e = (c == 1000 || c == 2000) ? 4'b0101 : 4'b0000;
                chk("rate3_err", {28'd0, err_a}, {28'd0, e});
            end
        end
        chk("rate3_cnt", {16'd0, cnt_a}, 32'd2);

        // Saturation at 15 on the 4-bit counter, then asynchronous mid-burst reset
        do_reset(4'd1, 1'b1, 4'b0101, 1'b0, 4'd1);
        wait_neg(195);
        chk("sat_a", {16'd0, cnt_a}, 32'd19);
        chk("sat_b", {28'd0, cnt_b}, 32'd15);
        start_of(196);
        BURST_LEN = 4'd8;
        wait_neg(203);
        chk("mid_err", {28'd0, err_a}, 32'h5);
        #1 RST = 1'b0;
        #1;
        chk("async_err", {28'd0, err_a}, 32'd0);
        chk("async_busy", {31'd0, busy_a}, 32'd0);
        chk("async_cnt", {16'd0, cnt_a}, 32'd0);
        do_reset(4'd1, 1'b1, 4'b0101, 1'b0, 4'd1);
        wait_neg(9);
        chk("post_rst_9", {28'd0, err_a}, 32'd0);
        wait_neg(10);
        chk("post_rst_10", {28'd0, err_a}, 32'h5);

        // Zero mask: triggers ignored entirely
        do_reset(4'd1, 1'b1, 4'b0000, 1'b0, 4'd1);
        wait_neg(25);
        chk("nomask_cnt", {16'd0, cnt_a}, 32'd0);
        chk("nomask_err", {28'd0, err_a}, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
